// File: rtl/edsac_mem_pkg.sv
// Shared constants and types for the EDSAC memory tank controller.
//
// Contents:
//   DIGITS_PER_MINOR  digit periods per minor cycle (17 data digits + 1 gap)
//   MINORS_PER_TANK   short-word slots circulating in one tank
//   WORD_W            short-word width in bits
//   tank_state_t      controller states. VERIFY_WAIT/VERIFY exist only when
//                     TANK_CTRL_VERIFY_EN is defined.
package edsac_mem_pkg;

    localparam int DIGITS_PER_MINOR = 18;
    localparam int MINORS_PER_TANK  = 32;
    localparam int WORD_W           = 17;

    localparam int D_W = 5;
    localparam int M_W = 5;

    // The last digit of every minor cycle is the inter-word gap.
    localparam logic [D_W-1:0] GAP_DIGIT  = D_W'(DIGITS_PER_MINOR - 1);
    localparam logic [M_W-1:0] LAST_MINOR = M_W'(MINORS_PER_TANK - 1);

`ifdef TANK_CTRL_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SLOT   = 3'd1,
        XFER        = 3'd2,
        DONE        = 3'd3,
        VERIFY_WAIT = 3'd4,
        VERIFY      = 3'd5
    } tank_state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        XFER      = 2'd2,
        DONE      = 2'd3
    } tank_state_t;
`endif

endpackage

// File: rtl/tank_timing_counter.sv
// Free-running tank timing: digit counter (0..17, 17 = gap) and minor
// counter (0..31). The minor count advances when the digit count wraps,
// so one full revolution of the tank is 18 * 32 = 576 cycles.
//
// Ports:
//   f2_clk     digit-period clock
//   f2_rst     synchronous active-high reset, counters return to 0
//   digit      current digit position
//   minor      current minor cycle (slot)
//   digit_nxt  value digit takes at the next edge (used for lookahead)
//   minor_nxt  value minor takes at the next edge
module tank_timing_counter
    import edsac_mem_pkg::*;
(
    input  logic           f2_clk,
    input  logic           f2_rst,
    output logic [D_W-1:0] digit,
    output logic [M_W-1:0] minor,
    output logic [D_W-1:0] digit_nxt,
    output logic [M_W-1:0] minor_nxt
);

    logic wrap_d;

    assign wrap_d    = (digit == GAP_DIGIT);
    assign digit_nxt = wrap_d ? '0 : digit + 5'd1;
    assign minor_nxt = !wrap_d ? minor :
                       (minor == LAST_MINOR) ? '0 : minor + 5'd1;

    always_ff @(posedge f2_clk) begin
        if (f2_rst) begin
            digit <= '0;
            minor <= '0;
        end else begin
            digit <= digit_nxt;
            minor <= minor_nxt;
        end
    end

endmodule

// File: rtl/memory_tank_ctrl.sv
// Memory tank access controller. Accepts one read or write request at a
// time, waits for the addressed short-word slot to come round in the tank,
// then drives the tank gates for the 17 data digits of that slot.
//
// Optional feature: define TANK_CTRL_VERIFY_EN to read back every write on
// the following revolution and flag a mismatch on err. Without it err is 0.
//
// Ports:
//   f2_clk, f2_rst        clock, synchronous active-high reset
//   req, we, addr, wdata  request (sampled only while idle)
//   busy                  acceptance through ack inclusive
//   ack                   one-cycle completion pulse (slot's gap digit)
//   rdata                 last read word, updated on read ack only
//   err                   write-verify mismatch, valid with ack
//   f2_down_t3_clr/in/out tank gates
//   f2_mib                serial write data, LSB first
//   f2_down_mob_t3        serial read data from the tank
//
// All gate outputs are registered. They are computed one cycle early from
// the counter lookahead (digit_nxt/minor_nxt) so that they are high exactly
// while the counters show digits 0..16 of the target slot.
module memory_tank_ctrl
    import edsac_mem_pkg::*;
(
    input  logic              f2_clk,
    input  logic              f2_rst,
    input  logic              req,
    input  logic              we,
    input  logic [M_W-1:0]    addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    output logic              f2_down_t3_clr,
    output logic              f2_down_t3_in,
    output logic              f2_down_t3_out,
    output logic              f2_mib,
    input  logic              f2_down_mob_t3
);

    logic [D_W-1:0]    digit, digit_nxt;
    logic [M_W-1:0]    minor, minor_nxt;

    tank_state_t       state;
    logic              we_q;
    logic [M_W-1:0]    addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rd_word;

    // Request fields as seen by the slot compare: live inputs while idle
    // (so a slot starting right after acceptance is not missed), latched
    // copies otherwise.
    logic              cur_we;
    logic [M_W-1:0]    cur_addr;
    logic [WORD_W-1:0] cur_wdata;

    logic              slot_hit;
    logic              last_bit;
    logic              go;
    logic              wr_nxt;
    logic              rd_nxt;
    logic              mib_nxt;

    tank_timing_counter u_timing (
        .f2_clk    (f2_clk),
        .f2_rst    (f2_rst),
        .digit     (digit),
        .minor     (minor),
        .digit_nxt (digit_nxt),
        .minor_nxt (minor_nxt)
    );

    assign cur_we    = (state == IDLE) ? we    : we_q;
    assign cur_addr  = (state == IDLE) ? addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? wdata : wdata_q;

    // Next cycle is digit 0 of the target slot.
    assign slot_hit = (digit_nxt == '0) && (minor_nxt == cur_addr);
    // Next cycle is the gap digit: this cycle carries the last data bit.
    assign last_bit = (digit_nxt == GAP_DIGIT);

    // Top bit comes straight off the bus in the same cycle it is captured.
    assign rd_word = {f2_down_mob_t3, shreg[WORD_W-2:0]};

    // Gate values for the next cycle.
    always_comb begin
        go      = 1'b0;
        wr_nxt  = 1'b0;
        rd_nxt  = 1'b0;
        mib_nxt = 1'b0;
        case (state)
            IDLE:      go = req && slot_hit;
            WAIT_SLOT: go = slot_hit;
            XFER: begin
                if (!last_bit) begin
                    wr_nxt = we_q;
                    rd_nxt = !we_q;
                end
            end
`ifdef TANK_CTRL_VERIFY_EN
            VERIFY_WAIT: rd_nxt = slot_hit;
            VERIFY:      rd_nxt = !last_bit;
`endif
            default: ;
        endcase
        if (go) begin
            wr_nxt = cur_we;
            rd_nxt = !cur_we;
        end
        if (wr_nxt && (digit_nxt < D_W'(WORD_W)))
            mib_nxt = cur_wdata[digit_nxt];
    end

`ifdef TANK_CTRL_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge f2_clk) begin
        if (f2_rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            ack            <= 1'b0;
            rdata          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            shreg          <= '0;
            f2_down_t3_clr <= 1'b0;
            f2_down_t3_in  <= 1'b0;
            f2_down_t3_out <= 1'b0;
            f2_mib         <= 1'b0;
`ifdef TANK_CTRL_VERIFY_EN
            err_q          <= 1'b0;
`endif
        end else begin
            ack            <= 1'b0;
            f2_down_t3_clr <= wr_nxt;
            f2_down_t3_in  <= wr_nxt;
            f2_down_t3_out <= rd_nxt;
            f2_mib         <= mib_nxt;

            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        state   <= slot_hit ? XFER : WAIT_SLOT;
                    end
                end

                WAIT_SLOT: begin
                    if (slot_hit)
                        state <= XFER;
                end

                // Digits 0..16 of the target slot.
                XFER: begin
                    shreg[digit] <= f2_down_mob_t3;
                    if (last_bit) begin
`ifdef TANK_CTRL_VERIFY_EN
                        if (we_q) begin
                            state <= VERIFY_WAIT;
                        end else begin
                            state <= DONE;
                            ack   <= 1'b1;
                            rdata <= rd_word;
                        end
`else
                        state <= DONE;
                        ack   <= 1'b1;
                        if (!we_q)
                            rdata <= rd_word;
`endif
                    end
                end

`ifdef TANK_CTRL_VERIFY_EN
                // The written slot only comes back one revolution later.
                VERIFY_WAIT: begin
                    if (slot_hit)
                        state <= VERIFY;
                end

                VERIFY: begin
                    shreg[digit] <= f2_down_mob_t3;
                    if (last_bit) begin
                        state <= DONE;
                        ack   <= 1'b1;
                        err_q <= (rd_word != wdata_q);
                    end
                end
`endif

                // Ack cycle; busy falls and the next request may follow.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef TANK_CTRL_VERIFY_EN
                    err_q <= 1'b0;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_tank_ctrl.sv
// Directed bench for memory_tank_ctrl with a behavioural tank model.
// Honours TANK_CTRL_VERIFY_EN for the write-ack latency and err checks.
module tb_memory_tank_ctrl;

`ifdef TANK_CTRL_VERIFY_EN
    localparam int  WR_ACK  = 107 + 576;
    localparam int  WR_OUTS = 17;
    localparam bit  VFY     = 1'b1;
`else
    localparam int  WR_ACK  = 107;
    localparam int  WR_OUTS = 0;
    localparam bit  VFY     = 1'b0;
`endif

    logic        f2_clk = 1'b0;
    logic        f2_rst;
    logic        req, we;
    logic [4:0]  addr;
    logic [16:0] wdata;
    logic        busy, ack, err;
    logic [16:0] rdata;
    logic        clr, gin, gout, mib, mob;

    memory_tank_ctrl dut (
        .f2_clk         (f2_clk),
        .f2_rst         (f2_rst),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .ack            (ack),
        .rdata          (rdata),
        .err            (err),
        .f2_down_t3_clr (clr),
        .f2_down_t3_in  (gin),
        .f2_down_t3_out (gout),
        .f2_mib         (mib),
        .f2_down_mob_t3 (mob)
    );

    always #5 f2_clk = ~f2_clk;

    // Reference digit/minor position.
    logic [4:0] tb_d, tb_m;
    always @(posedge f2_clk) begin
        if (f2_rst) begin
            tb_d <= 5'd0;
            tb_m <= 5'd0;
        end else if (tb_d == 5'd17) begin
            tb_d <= 5'd0;
            tb_m <= tb_m + 5'd1;
        end else begin
            tb_d <= tb_d + 5'd1;
        end
    end

    // Tank model: one word per slot; optional bit-3 corruption of slot 5.
    logic [16:0] tank [32];
    logic        corrupt = 1'b0;
    always @(posedge f2_clk) begin
        if (f2_rst)
            tank[31] <= 17'h0A5A5;
        else if (gin && tb_d < 5'd17)
            tank[tb_m][tb_d] <= mib ^ (corrupt && tb_m == 5'd5 && tb_d == 5'd3);
    end
    always_comb begin
        mob = 1'b0;
        if (gout && tb_d < 5'd17)
            mob = tank[tb_m][tb_d];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_md(input logic [4:0] mm, input logic [4:0] dd);
        int n = 0;
        while (!(tb_m == mm && tb_d == dd) && n < 1200) begin
            @(negedge f2_clk);
            n++;
        end
        chk("wait_md", 32'(n < 1200), 32'd1);
    endtask

    // Write run results.
    int          w_first_in, w_in_cnt, w_out_cnt, w_ack_cnt, w_ack_cyc, w_stray;
    logic        w_err, w_busy1, w_busy_after;
    logic [16:0] w_mib;

    task automatic run_write(input logic [4:0] a, input logic [16:0] wd, input int cycles, input bit poke);
        w_first_in = -1; w_in_cnt = 0; w_out_cnt = 0; w_ack_cnt = 0; w_ack_cyc = -1;
        w_stray = 0; w_err = 1'b0; w_busy1 = 1'b0; w_busy_after = 1'b1; w_mib = '0;
        req = 1'b1; we = 1'b1; addr = a; wdata = wd;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge f2_clk);
            if (k == 1) begin
                req = 1'b0;
                w_busy1 = busy;
            end
            if (poke && k == 20) begin
                req = 1'b1; we = 1'b0; addr = 5'd9; wdata = 17'h00F0F;
            end
            if (poke && k == 21) req = 1'b0;
            if (clr && gin) begin
                if (w_in_cnt == 0) w_first_in = k;
                w_in_cnt++;
                if (tb_d < 5'd17) w_mib[tb_d] = mib;
            end
            if (!gin && mib) w_stray++;
            if (gout) w_out_cnt++;
            if (ack) begin
                w_ack_cnt++;
                w_ack_cyc = k;
                w_err = err;
            end
            if (w_ack_cyc > 0 && k == w_ack_cyc + 1) w_busy_after = busy;
        end
    endtask

    // Read run results.
    int          r_first_out, r_out_cnt, r_wr_cnt, r_ack_cnt, r_ack_cyc;
    logic [4:0]  r_ack_m, r_ack_d, r_m_after;
    logic [16:0] r_rdata;
    logic        r_err;

    task automatic run_read(input logic [4:0] a, input int cycles);
        r_first_out = -1; r_out_cnt = 0; r_wr_cnt = 0; r_ack_cnt = 0; r_ack_cyc = -1;
        r_ack_m = '1; r_ack_d = '1; r_m_after = '1; r_rdata = '0; r_err = 1'b1;
        req = 1'b1; we = 1'b0; addr = a; wdata = 17'h1FFFF;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge f2_clk);
            if (k == 1) req = 1'b0;
            if (gout) begin
                if (r_out_cnt == 0) r_first_out = k;
                r_out_cnt++;
            end
            if (clr || gin) r_wr_cnt++;
            if (r_ack_cyc > 0 && k == r_ack_cyc + 1) r_m_after = dut.minor;
            if (ack) begin
                r_ack_cnt++;
                r_ack_cyc = k;
                r_ack_m = dut.minor;
                r_ack_d = dut.digit;
                r_rdata = rdata;
                r_err = err;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        f2_rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge f2_clk);
        @(negedge f2_clk);

        // Reset state (cycle with d=0, m=0).
        chk("rst_d",     32'(dut.digit), 32'd0);
        chk("rst_m",     32'(dut.minor), 32'd0);
        chk("rst_ctl",   {28'd0, busy, ack, err, mib}, 32'd0);
        chk("rst_gates", {29'd0, clr, gin, gout}, 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        f2_rst = 1'b0;

        // Idle for 1000 cycles.
        bad = 0;
        repeat (1000) begin
            @(negedge f2_clk);
            if (busy || ack || err || clr || gin || gout || mib) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_cnt_sync", {dut.minor, dut.digit}, {tb_m, tb_d});

        // Write 1ABCD to slot 5 from (m=0,d=0) with a stray request while busy.
        wait_md(5'd0, 5'd0);
        run_write(5'd5, 17'h1ABCD, WR_ACK + 2, 1'b1);
        chk("wr_busy_accept", 32'(w_busy1), 32'd1);
        chk("wr_first_in",    w_first_in, 90);
        chk("wr_in_cycles",   w_in_cnt, 17);
        chk("wr_mib_word",    32'(w_mib), 32'h1ABCD);
        chk("wr_mib_stray",   w_stray, 0);
        chk("wr_out_cycles",  w_out_cnt, WR_OUTS);
        chk("wr_ack_cnt",     w_ack_cnt, 1);
        chk("wr_ack_cyc",     w_ack_cyc, WR_ACK);
        chk("wr_err",         32'(w_err), 32'd0);
        chk("wr_busy_after",  32'(w_busy_after), 32'd0);
        chk("tank5",          32'(tank[5]), 32'h1ABCD);

        // Read it back.
        run_read(5'd5, 600);
        chk("rd5_ack_cnt", r_ack_cnt, 1);
        chk("rd5_rdata",   32'(r_rdata), 32'h1ABCD);
        chk("rd5_outs",    r_out_cnt, 17);
        chk("rd5_no_wr",   r_wr_cnt, 0);
        chk("rd5_err",     32'(r_err), 32'd0);
        chk("rd5_hold",    32'(rdata), 32'h1ABCD);

        // Read slot 31 accepted exactly at its own start: full revolution.
        wait_md(5'd31, 5'd0);
        run_read(5'd31, 600);
        chk("rd31_first_out", r_first_out, 576);
        chk("rd31_ack_cyc",   r_ack_cyc, 593);
        chk("rd31_ack_md",    {r_ack_m, r_ack_d}, {5'd31, 5'd17});
        chk("rd31_m_wrap",    32'(r_m_after), 32'd0);
        chk("rd31_rdata",     32'(r_rdata), 32'h0A5A5);

        // Corrupting tank: only the verify build notices.
        wait_md(5'd0, 5'd0);
        corrupt = 1'b1;
        run_write(5'd5, 17'h1ABCD, WR_ACK + 2, 1'b0);
        corrupt = 1'b0;
        chk("cor_ack_cyc", w_ack_cyc, WR_ACK);
        chk("cor_err",     32'(w_err), 32'(VFY));
        chk("cor_ack_cnt", w_ack_cnt, 1);

        // Reset in the middle of a write at d=8.
        wait_md(5'd0, 5'd0);
        req = 1'b1; we = 1'b1; addr = 5'd2; wdata = 17'h15555;
        for (int k = 1; k <= 44; k++) begin
            @(negedge f2_clk);
            if (k == 1) req = 1'b0;
        end
        chk("mid_d8",  32'(dut.digit), 32'd8);
        chk("mid_in",  32'(gin), 32'd1);
        f2_rst = 1'b1;
        @(negedge f2_clk);
        chk("mid_rst_gates", {28'd0, clr, gin, gout, mib}, 32'd0);
        chk("mid_rst_ctl",   {30'd0, busy, ack}, 32'd0);
        chk("mid_rst_cnt",   {dut.minor, dut.digit}, 10'd0);
        f2_rst = 1'b0;
        bad = 0;
        repeat (700) begin
            @(negedge f2_clk);
            if (ack || busy || clr || gin || gout) bad++;
        end
        chk("mid_no_ack", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
